sm83_irq_ctl: RTL and testbench
===============================

SM83_IRQ_CTL -- requirements
Module: sm83_irq_ctl

Interface
REQ-001 Parameter NUM_IRQS, default 8, number of interrupt sources.
REQ-002 Parameter VEC_BASE, default 16'h0040, vector of source 0.
REQ-003 Parameter VEC_STRIDE, default 8, vector spacing between consecutive sources.
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 m_end  input  1  one-clk strobe on the last clk of every M-cycle.
REQ-007 instr_end  input  1  qualifies m_end on the last M-cycle of an instruction.
REQ-008 op_ei, op_di, op_reti, op_halt  input  1 each  decoded type of the ending instruction; sampled only when m_end && instr_end.
REQ-009 irq  input  NUM_IRQS  pending requests, already masked by IE and IF, level.
REQ-010 ime  output  1  interrupt master enable.
REQ-011 halted  output  1  CPU is in HALT; fetch suppressed.
REQ-012 dispatch  output  1  high for the whole dispatch sequence D1..D5.
REQ-013 disp_m  output  3  current dispatch M-cycle, 1..5; 0 when not dispatching.
REQ-014 iack  output  NUM_IRQS  one-hot acknowledge pulse, one clk wide.
REQ-015 vector  output  16  jump target; valid during D5.

Function
REQ-016 States: IDLE, HALT, D1, D2, D3, D4, D5; transitions only on clk where m_end=1, except reset.
REQ-017 "end" below means m_end && instr_end with state IDLE.
REQ-018 EI at end: set ime_pend; ime unchanged.
REQ-019 Any end with ime_pend=1 and op_ei=0: ime<=1, ime_pend<=0.
REQ-020 DI at end: ime<=0, ime_pend<=0; DI wins over a pending EI.
REQ-021 RETI at end: ime<=1 in the same clk.
REQ-022 Dispatch check at end uses post-update ime, with pending = |irq. If ime && pending: go to D1, ime<=0. The EI instruction's own end never dispatches.
REQ-023 HALT at end with no dispatch: go to HALT, halted=1.
REQ-024 In HALT, each m_end with pending=1: if ime, go to D1 with halted<=0 and ime<=0; else go to IDLE with halted<=0 and no dispatch.
REQ-025 In HALT with pending=0: hold.
REQ-026 D1..D4 advance to the next state on each m_end.
REQ-027 On m_end in D4, resolve priority: n = lowest set index of irq sampled at that clk.
REQ-028 On that same clk, iack = one-hot n for one clk, and vector <= VEC_BASE + n*VEC_STRIDE.
REQ-029 If irq=0 at the D4 resolve (cancelled request): iack stays 0 and vector <= 16'h0000.
REQ-030 D5: vector is stable; on m_end go to IDLE, dispatch<=0, disp_m<=0.
REQ-031 Total dispatch latency is exactly 5 M-cycles from the end of the triggering instruction.
REQ-032 op_* inputs and instr_end are ignored outside IDLE.
REQ-033 iack is 0 on every clk other than the D4 resolve clk.
REQ-034 vector width rule: sum computed in 16 bits, no wrap for NUM_IRQS <= 8.

Reset
REQ-035 While reset=0, outputs asynchronously go to: state IDLE, ime=0, ime_pend=0, halted=0, dispatch=0, disp_m=0, iack=0, vector=16'h0000.
REQ-036 Reset asserted mid-dispatch or in HALT aborts with no iack.
REQ-037 After release, the first state change occurs no earlier than the next m_end.

Structure
REQ-038 State enum, VEC_BASE/VEC_STRIDE defaults and the disp_m encoding live in a shared package, sm83_pkg.
REQ-039 Priority resolution lives in one sub-module, sm83_irq_prio: combinational lowest-set-bit encoder producing a one-hot output, an index and a valid flag.
REQ-040 The rest of the block is a single state register plus the ime/ime_pend flags.

Verification
REQ-041 Interrupt while enabled: ime=1, irq=8'h05 at an end -> D1..D5 follow, iack=8'h01 at D4 m_end, vector=16'h0040, ime=0.
REQ-042 EI delay: EI end, then next end with irq=8'h04 -> ime=1 after the EI+1 end; dispatch starts at that end only if the post-update rule allows; iack=8'h04, vector=16'h0050.
REQ-043 Cancelled request: dispatch started with irq=8'h02, irq dropped to 0 before D4 m_end -> iack=0, vector=16'h0000.
REQ-044 HALT wake with ime=0: HALT end, irq=8'h10 three M-cycles later -> halted=0, state IDLE, dispatch never asserted.
REQ-045 HALT wake with ime=1: irq=8'h10 -> D1..D5, iack=8'h10, vector=16'h0060.
REQ-046 Reset in D3: reset=0 -> immediately state IDLE, dispatch=0, ime=0, no iack pulse.

Source files
------------

// File: rtl/sm83_pkg.sv
// Shared definitions for the SM83 interrupt controller: controller states,
// default vector layout and the dispatch M-cycle encoding.
package sm83_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HALT = 3'd1,
      ST_D1   = 3'd2,
      ST_D2   = 3'd3,
      ST_D3   = 3'd4,
      ST_D4   = 3'd5,
      ST_D5   = 3'd6
   } irq_state_e;

   localparam logic [15:0] VEC_BASE_DEF   = 16'h0040;
   localparam int          VEC_STRIDE_DEF = 8;

   localparam logic [2:0] DISP_M_NONE = 3'd0;
   localparam logic [2:0] DISP_M_D1   = 3'd1;
   localparam logic [2:0] DISP_M_D2   = 3'd2;
   localparam logic [2:0] DISP_M_D3   = 3'd3;
   localparam logic [2:0] DISP_M_D4   = 3'd4;
   localparam logic [2:0] DISP_M_D5   = 3'd5;

   function automatic logic [2:0] disp_m_of(input irq_state_e s);
      case (s)
         ST_D1:   return DISP_M_D1;
         ST_D2:   return DISP_M_D2;
         ST_D3:   return DISP_M_D3;
         ST_D4:   return DISP_M_D4;
         ST_D5:   return DISP_M_D5;
         default: return DISP_M_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sm83_irq_ctl_if.sv
// CPU-core <-> interrupt controller signal bundle; master is the core side,
// slave is the controller.
interface sm83_irq_ctl_if #(
   parameter int NUM_IRQS = 8
) ();
   logic                m_end;
   logic                instr_end;
   logic                op_ei;
   logic                op_di;
   logic                op_reti;
   logic                op_halt;
   logic [NUM_IRQS-1:0] irq;
   logic                ime;
   logic                halted;
   logic                dispatch;
   logic [2:0]          disp_m;
   logic [NUM_IRQS-1:0] iack;
   logic [15:0]         vector;

   modport master (
      output m_end, instr_end, op_ei, op_di, op_reti, op_halt, irq,
      input  ime, halted, dispatch, disp_m, iack, vector
   );

   modport slave (
      input  m_end, instr_end, op_ei, op_di, op_reti, op_halt, irq,
      output ime, halted, dispatch, disp_m, iack, vector
   );
endinterface

// File: rtl/sm83_irq_prio.sv
// Combinational lowest-set-bit priority encoder: one-hot grant, binary index
// and a valid flag when any request is set.
module sm83_irq_prio #(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan from the top down so the lowest set bit is the last one to win.
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = |req;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = IW'(i);
         end
      end
   end

endmodule

// File: rtl/sm83_irq_ctl.sv
// SM83 interrupt controller: IME/EI-delay tracking, HALT wake-up and the
// five M-cycle interrupt dispatch sequence with priority resolve in D4.
module sm83_irq_ctl
   import sm83_pkg::*;
#(
   parameter int          NUM_IRQS   = 8,
   parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
   parameter int          VEC_STRIDE = VEC_STRIDE_DEF
) (
   input  logic         clk,
   input  logic         reset,
   sm83_irq_ctl_if.slave bus
);

   localparam int IW = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

   irq_state_e          state_q, state_d;
   logic                ime_q, ime_d;
   logic                ime_pend_q, ime_pend_d;
   logic [15:0]         vector_q, vector_d;
   logic [NUM_IRQS-1:0] iack_c;

   logic [NUM_IRQS-1:0] prio_oh;
   logic [IW-1:0]       prio_idx;
   logic                prio_vld;
   logic                pending;
   logic [15:0]         vec_calc;

   sm83_irq_prio #(
      .N  (NUM_IRQS),
      .IW (IW)
   ) u_prio (
      .req    (bus.irq),
      .onehot (prio_oh),
      .idx    (prio_idx),
      .valid  (prio_vld)
   );

   assign pending  = |bus.irq;
   assign vec_calc = VEC_BASE + (16'(prio_idx) * 16'(VEC_STRIDE));

   always_comb begin
      state_d    = state_q;
      ime_d      = ime_q;
      ime_pend_d = ime_pend_q;
      vector_d   = vector_q;
      iack_c     = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.m_end && bus.instr_end) begin
               if (bus.op_di) begin
                  ime_d      = 1'b0;
                  ime_pend_d = 1'b0;
               end else if (bus.op_ei) begin
                  ime_pend_d = 1'b1;
               end else if (ime_pend_q) begin
                  ime_d      = 1'b1;
                  ime_pend_d = 1'b0;
               end
               if (bus.op_reti) ime_d = 1'b1;
               // Dispatch decision sees the IME value this instruction leaves behind.
               if (!bus.op_ei && ime_d && pending) begin
                  state_d = ST_D1;
                  ime_d   = 1'b0;
               end else if (bus.op_halt) begin
                  state_d = ST_HALT;
               end
            end
         end
         ST_HALT: begin
            if (bus.m_end && pending) begin
               if (ime_q) begin
                  state_d = ST_D1;
                  ime_d   = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_D1: if (bus.m_end) state_d = ST_D2;
         ST_D2: if (bus.m_end) state_d = ST_D3;
         ST_D3: if (bus.m_end) state_d = ST_D4;
         ST_D4: begin
            // A request withdrawn before this point yields no ack and a zero vector.
            if (bus.m_end) begin
               state_d  = ST_D5;
               iack_c   = prio_oh;
               vector_d = prio_vld ? vec_calc : 16'h0000;
            end
         end
         ST_D5: if (bus.m_end) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ime_q      <= 1'b0;
         ime_pend_q <= 1'b0;
         vector_q   <= 16'h0000;
      end else begin
         state_q    <= state_d;
         ime_q      <= ime_d;
         ime_pend_q <= ime_pend_d;
         vector_q   <= vector_d;
      end
   end

   assign bus.ime      = ime_q;
   assign bus.halted   = (state_q == ST_HALT);
   assign bus.disp_m   = disp_m_of(state_q);
   assign bus.dispatch = (disp_m_of(state_q) != DISP_M_NONE);
   assign bus.iack     = iack_c;
   assign bus.vector   = vector_q;

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Directed bench for sm83_irq_ctl: M-cycles of four clocks, expected values
// written out by hand for each scenario.
module tb_sm83_irq_ctl;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   iack_cnt;
   int   disp_cnt;
   logic [7:0] iack_last;

   sm83_irq_ctl_if #(.NUM_IRQS(8)) bus ();

   sm83_irq_ctl #(.NUM_IRQS(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      iack_cnt  = 0;
      disp_cnt  = 0;
      iack_last = 8'h00;
   end

   always @(negedge clk) begin
      if (bus.iack != 8'h00) begin
         iack_cnt  <= iack_cnt + 1;
         iack_last <= bus.iack;
      end
      if (bus.dispatch) disp_cnt <= disp_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One M-cycle: three idle clocks then one clock carrying m_end.
   task automatic mcyc(input logic ie, input logic ei, input logic di,
                       input logic reti, input logic halt);
      repeat (3) @(posedge clk);
      #1;
      bus.m_end = 1'b1; bus.instr_end = ie;
      bus.op_ei = ei; bus.op_di = di; bus.op_reti = reti; bus.op_halt = halt;
      @(posedge clk);
      #1;
      bus.m_end = 1'b0; bus.instr_end = 1'b0;
      bus.op_ei = 1'b0; bus.op_di = 1'b0; bus.op_reti = 1'b0; bus.op_halt = 1'b0;
   endtask

   // Called with the controller already in D1.
   task automatic run_disp(input string tag, input logic [7:0] exp_iack,
                           input logic [15:0] exp_vec);
      int base;
      base = iack_cnt;
      for (int k = 2; k <= 5; k++) begin
         mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         chk({tag, "_dm"}, 32'(bus.disp_m), 32'(k));
      end
      chk({tag, "_iack_n"}, 32'(iack_cnt - base), 32'd1);
      chk({tag, "_iack"}, 32'(iack_last), 32'(exp_iack));
      chk({tag, "_vec"}, 32'(bus.vector), 32'(exp_vec));
      mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk({tag, "_end_dm"}, 32'(bus.disp_m), 32'd0);
      chk({tag, "_end_disp"}, 32'(bus.dispatch), 32'd0);
   endtask

   initial begin
      int base;
      total = 0;
      bad   = 0;
      reset = 1'b0;
      bus.m_end = 1'b0; bus.instr_end = 1'b0;
      bus.op_ei = 1'b0; bus.op_di = 1'b0; bus.op_reti = 1'b0; bus.op_halt = 1'b0;
      bus.irq = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ime", 32'(bus.ime), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_disp", 32'(bus.dispatch), 32'd0);
      chk("rst_dm", 32'(bus.disp_m), 32'd0);
      chk("rst_iack", 32'(bus.iack), 32'd0);
      chk("rst_vec", 32'(bus.vector), 32'd0);
      reset = 1'b1;

      // RETI sets IME; then a plain end with irq=05 dispatches source 0.
      mcyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("reti_ime", 32'(bus.ime), 32'd1);
      chk("reti_dm", 32'(bus.disp_m), 32'd0);
      bus.irq = 8'h05;
      mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("i05_dm", 32'(bus.disp_m), 32'd1);
      chk("i05_ime", 32'(bus.ime), 32'd0);
      @(posedge clk); #1;
      chk("i05_hold_dm", 32'(bus.disp_m), 32'd1);
      run_disp("i05", 8'h01, 16'h0040);
      bus.irq = 8'h00;

      // EI with IME already set never dispatches on its own end.
      mcyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.irq = 8'h01;
      mcyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("ei_own_dm", 32'(bus.disp_m), 32'd0);
      chk("ei_own_ime", 32'(bus.ime), 32'd1);
      mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ei_own_next_dm", 32'(bus.disp_m), 32'd1);
      run_disp("ei_own", 8'h01, 16'h0040);

      // EI delay: IME becomes 1 only at the following end, which dispatches.
      bus.irq = 8'h04;
      mcyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("eid_ime", 32'(bus.ime), 32'd0);
      chk("eid_dm", 32'(bus.disp_m), 32'd0);
      mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("eid_next_dm", 32'(bus.disp_m), 32'd1);
      chk("eid_next_ime", 32'(bus.ime), 32'd0);
      run_disp("eid", 8'h04, 16'h0050);
      bus.irq = 8'h00;

      // DI cancels a pending EI.
      mcyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      mcyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("di_ime", 32'(bus.ime), 32'd0);

      // Cancelled request: irq drops before the D4 resolve.
      mcyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.irq = 8'h02;
      mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("cx_dm1", 32'(bus.disp_m), 32'd1);
      repeat (3) mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("cx_dm4", 32'(bus.disp_m), 32'd4);
      base = iack_cnt;
      bus.irq = 8'h00;
      mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("cx_dm5", 32'(bus.disp_m), 32'd5);
      chk("cx_iack_n", 32'(iack_cnt - base), 32'd0);
      chk("cx_vec", 32'(bus.vector), 32'd0);
      mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("cx_end_dm", 32'(bus.disp_m), 32'd0);

      // HALT with IME=0 wakes to IDLE without dispatch; ops ignored while halted.
      base = disp_cnt;
      mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("h0_halted", 32'(bus.halted), 32'd1);
      mcyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("h0_ign_ime", 32'(bus.ime), 32'd0);
      chk("h0_hold", 32'(bus.halted), 32'd1);
      bus.irq = 8'h10;
      @(posedge clk); #1;
      chk("h0_wait_mend", 32'(bus.halted), 32'd1);
      mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("h0_wake", 32'(bus.halted), 32'd0);
      chk("h0_dm", 32'(bus.disp_m), 32'd0);
      mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("h0_no_disp", 32'(disp_cnt - base), 32'd0);
      bus.irq = 8'h00;

      // HALT with IME=1 wakes straight into dispatch of source 4.
      mcyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("h1_halted", 32'(bus.halted), 32'd1);
      mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.irq = 8'h10;
      mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("h1_wake", 32'(bus.halted), 32'd0);
      chk("h1_dm", 32'(bus.disp_m), 32'd1);
      chk("h1_ime", 32'(bus.ime), 32'd0);
      run_disp("h1", 8'h10, 16'h0060);
      bus.irq = 8'h00;

      // Reset asserted in D3 aborts asynchronously with no ack.
      mcyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.irq = 8'h01;
      mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("r3_dm3", 32'(bus.disp_m), 32'd3);
      base = iack_cnt;
      #2 reset = 1'b0;
      #1;
      chk("r3_dm", 32'(bus.disp_m), 32'd0);
      chk("r3_disp", 32'(bus.dispatch), 32'd0);
      chk("r3_ime", 32'(bus.ime), 32'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("r3_iack_n", 32'(iack_cnt - base), 32'd0);
      chk("r3_idle", 32'(bus.disp_m), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
